// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection, operand forwarding, branch flush and halt drain for the 5-stage pipeline.
// Optional feature macro: HAZARD_FORWARD_EN (forwarding on, only load-use hazards stall).
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    input  logic [3:0]       RaD,
    input  logic [3:0]       RbD,
    input  logic             UseRaD,
    input  logic             UseRbD,
    input  logic [3:0]       RdE,
    input  logic             RegWriteE,
    input  logic [1:0]       MemToRegE,
    input  logic [3:0]       RdM,
    input  logic             RegWriteM,
    input  logic [1:0]       MemToRegM,
    input  logic [3:0]       RdW,
    input  logic             RegWriteW,
    input  logic             PCSrcW,
    output logic             PCEn,
    output logic             FDEn,
    output logic             FDClr,
    output logic             DEClr,
    output logic             EMClr,
    output logic             MWClr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCount
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_drain_cnt;
    logic [1:0]       w_drain_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_stall;
    logic             w_stall_applied;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    // R15 is the PC and never participates in a dependency.
    function automatic logic src_match(input logic use_s, input logic [3:0] rs,
                                       input logic [3:0] rd, input logic we);
        return use_s && we && (rs == rd) && (rd != 4'd15);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

`ifdef HAZARD_FORWARD_EN
    logic [3:0] r_ra_p1;
    logic [3:0] r_rb_p1;
    logic       r_use_ra_p1;
    logic       r_use_rb_p1;

    // Decode -> Execute: source tags follow the instruction; a cleared slot carries no reads.
    always_ff @(posedge clk) begin
        r_ra_p1 <= RaD;
        r_rb_p1 <= RbD;
        if (reset) begin
            r_use_ra_p1 <= 1'b0;
            r_use_rb_p1 <= 1'b0;
        end else begin
            r_use_ra_p1 <= UseRaD & ~DEClr;
            r_use_rb_p1 <= UseRbD & ~DEClr;
        end
    end

    // A load still in Memory has no data to forward yet; Memory shadows WriteBack regardless.
    function automatic logic [1:0] fwd_sel(input logic use_s, input logic [3:0] rs);
        if (src_match(use_s, rs, RdM, RegWriteM))
            return (MemToRegM == 2'b00) ? 2'b10 : 2'b00;
        else if (src_match(use_s, rs, RdW, RegWriteW))
            return 2'b01;
        return 2'b00;
    endfunction

    assign w_stall = (src_match(UseRaD, RaD, RdE, RegWriteE) ||
                      src_match(UseRbD, RbD, RdE, RegWriteE)) && (MemToRegE != 2'b00);
    assign w_fwd_a = fwd_sel(r_use_ra_p1, r_ra_p1);
    assign w_fwd_b = fwd_sel(r_use_rb_p1, r_rb_p1);
`else
    logic w_unused;

    assign w_stall = src_match(UseRaD, RaD, RdE, RegWriteE) || src_match(UseRbD, RbD, RdE, RegWriteE) ||
                     src_match(UseRaD, RaD, RdM, RegWriteM) || src_match(UseRbD, RbD, RdM, RegWriteM) ||
                     src_match(UseRaD, RaD, RdW, RegWriteW) || src_match(UseRbD, RbD, RdW, RegWriteW);
    assign w_fwd_a  = 2'b00;
    assign w_fwd_b  = 2'b00;
    assign w_unused = ^{MemToRegE, MemToRegM};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_drain_cnt <= 2'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            if (w_stall_applied)
                r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            RUN: begin
                if (halt) begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = 2'd0;
                end
            end
            DRAIN: begin
                if (!halt) begin
                    w_state_nxt     = RUN;
                    w_drain_cnt_nxt = 2'd0;
                end else if (PCSrcW) begin
                    w_drain_cnt_nxt = 2'd0;
                end else if (r_drain_cnt == 2'd3) begin
                    w_state_nxt     = HALTED;
                    w_drain_cnt_nxt = 2'd0;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + 2'd1;
                end
            end
            HALTED: begin
                if (!halt)
                    w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        PCEn            = 1'b1;
        FDEn            = 1'b1;
        FDClr           = 1'b0;
        DEClr           = 1'b0;
        EMClr           = 1'b0;
        MWClr           = 1'b0;
        ForwardAE       = w_fwd_a;
        ForwardBE       = w_fwd_b;
        Halted          = 1'b0;
        w_stall_applied = 1'b0;
        if (reset) begin
            PCEn      = 1'b0;
            FDEn      = 1'b0;
            {FDClr, DEClr, EMClr, MWClr} = 4'b1111;
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
        end else if (PCSrcW) begin
            {FDClr, DEClr, EMClr, MWClr} = 4'b1111;
        end else if (r_state == DRAIN) begin
            PCEn  = 1'b0;
            FDClr = 1'b1;
        end else if (r_state == HALTED) begin
            PCEn   = 1'b0;
            FDEn   = 1'b0;
            {FDClr, DEClr, EMClr, MWClr} = 4'b1111;
            Halted = 1'b1;
        end else if (w_stall) begin
            PCEn            = 1'b0;
            FDEn            = 1'b0;
            DEClr           = 1'b1;
            w_stall_applied = 1'b1;
        end
    end

    assign StallCount = r_stall_cnt;
endmodule
